// File: rtl/multi_cycle_control_fsm_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath.
// master = the sequencer (drives enables/selects), slave = the datapath side.
interface multi_cycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             zero;
    logic [3:0]       state;
    logic             PCWrite;
    logic [1:0]       PCSrc;
    logic             IRWrite;
    logic             ExtSrc;
    logic             ALUSrcB;
    logic [2:0]       ALUOp;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       RegDst;
    logic             WrDataSrc;
    logic             MemtoReg;
    logic [CNT_W-1:0] InsCount;

    modport master (
        input  op, func, zero,
        output state, PCWrite, PCSrc, IRWrite, ExtSrc, ALUSrcB, ALUOp,
               MemRead, MemWrite, RegWrite, RegDst, WrDataSrc, MemtoReg, InsCount
    );

    modport slave (
        output op, func, zero,
        input  state, PCWrite, PCSrc, IRWrite, ExtSrc, ALUSrcB, ALUOp,
               MemRead, MemWrite, RegWrite, RegDst, WrDataSrc, MemtoReg, InsCount
    );
endinterface

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle MIPS sequencer: walks IF/ID/EXE/MEM/WB and decodes per-cycle
// datapath controls from the current state and opcode; counts retired instructions.
module multi_cycle_control_fsm #(
    parameter logic [5:0] HALT_OP = 6'b111111,
    parameter int         CNT_W   = 32
) (
    input logic                      CLK,
    input logic                      Reset,
    multi_cycle_control_fsm_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_WB_AL  = 4'd3,
        S_EXE_BR = 4'd4,
        S_EXE_LS = 4'd5,
        S_MEM    = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ins_count_q;

    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       wr_data_src, mem_to_reg, ext_src, alu_src_b;
    logic [1:0] pc_src, reg_dst;
    logic [2:0] alu_op;
    logic       alu_active;
    logic       ext_src_dec, alu_src_b_dec;
    logic [2:0] alu_op_dec;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IF;
            ins_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_write) ins_count_q <= ins_count_q + CNT_W'(1);
        end
    end

    // ALU setup depends only on the opcode, so it stays stable from EXE to retirement.
    always_comb begin
        alu_op_dec    = 3'b000;
        alu_src_b_dec = 1'b0;
        ext_src_dec   = 1'b0;
        case (bus.op)
            OP_RTYPE:              alu_op_dec = 3'b111;
            OP_ADDIU, OP_LW, OP_SW: begin
                alu_src_b_dec = 1'b1;
                ext_src_dec   = 1'b1;
            end
            OP_SLTI: begin
                alu_op_dec    = 3'b100;
                alu_src_b_dec = 1'b1;
                ext_src_dec   = 1'b1;
            end
            OP_ANDI: begin
                alu_op_dec    = 3'b010;
                alu_src_b_dec = 1'b1;
            end
            OP_ORI: begin
                alu_op_dec    = 3'b011;
                alu_src_b_dec = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op_dec  = 3'b001;
                ext_src_dec = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        wr_data_src = 1'b0;
        mem_to_reg  = 1'b0;
        alu_active  = 1'b0;
        case (state_q)
            S_IF: begin
                ir_write = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                if (bus.op == HALT_OP) begin
                    state_d = S_HALT;
                end else begin
                    case (bus.op)
                        OP_J: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                            state_d  = S_IF;
                        end
                        OP_JAL: begin
                            pc_write  = 1'b1;
                            pc_src    = 2'b10;
                            reg_write = 1'b1;
                            reg_dst   = 2'b10;
                            state_d   = S_IF;
                        end
                        OP_RTYPE: begin
                            if (bus.func == FUNC_JR) begin
                                pc_write = 1'b1;
                                pc_src   = 2'b11;
                                state_d  = S_IF;
                            end else begin
                                state_d = S_EXE_AL;
                            end
                        end
                        OP_BEQ, OP_BNE:                     state_d = S_EXE_BR;
                        OP_LW, OP_SW:                       state_d = S_EXE_LS;
                        OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXE_AL;
                        default: begin
                            pc_write = 1'b1;
                            state_d  = S_IF;
                        end
                    endcase
                end
            end
            S_EXE_AL: begin
                alu_active = 1'b1;
                state_d    = S_WB_AL;
            end
            S_WB_AL: begin
                alu_active  = 1'b1;
                reg_write   = 1'b1;
                reg_dst     = (bus.op == OP_RTYPE) ? 2'b01 : 2'b00;
                wr_data_src = 1'b1;
                pc_write    = 1'b1;
                state_d     = S_IF;
            end
            S_EXE_BR: begin
                alu_active = 1'b1;
                pc_write   = 1'b1;
                if (((bus.op == OP_BEQ) && bus.zero) || ((bus.op == OP_BNE) && !bus.zero))
                    pc_src = 2'b01;
                state_d = S_IF;
            end
            S_EXE_LS: begin
                alu_active = 1'b1;
                state_d    = S_MEM;
            end
            S_MEM: begin
                alu_active = 1'b1;
                if (bus.op == OP_LW) begin
                    mem_read = 1'b1;
                    state_d  = S_WB_LD;
                end else begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_WB_LD: begin
                alu_active  = 1'b1;
                mem_read    = 1'b1;
                reg_write   = 1'b1;
                mem_to_reg  = 1'b1;
                wr_data_src = 1'b1;
                pc_write    = 1'b1;
                state_d     = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    assign alu_op    = alu_active ? alu_op_dec    : 3'b000;
    assign alu_src_b = alu_active ? alu_src_b_dec : 1'b0;
    assign ext_src   = alu_active ? ext_src_dec   : 1'b0;

    // NOTE: the enables are gated by Reset combinationally so they drop the
    // instant reset asserts, not at the next clock edge.
    assign bus.PCWrite   = pc_write  & Reset;
    assign bus.IRWrite   = ir_write  & Reset;
    assign bus.RegWrite  = reg_write & Reset;
    assign bus.MemRead   = mem_read  & Reset;
    assign bus.MemWrite  = mem_write & Reset;
    assign bus.PCSrc     = pc_src;
    assign bus.ExtSrc    = ext_src;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.RegDst    = reg_dst;
    assign bus.WrDataSrc = wr_data_src;
    assign bus.MemtoReg  = mem_to_reg;
    assign bus.state     = state_q;
    assign bus.InsCount  = ins_count_q;
endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Self-checking bench for multi_cycle_control_fsm: table vectors, hand-written
// corner sequences and random instruction streams against a path-based model.
module tb_multi_cycle_control_fsm;
    // Narrow counter so wrap-around is reached within the run.
    localparam int CNT_W = 5;

    logic CLK;
    logic Reset;
    int   vectors;
    int   miscompares;
    int unsigned cnt_m;

    multi_cycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    multi_cycle_control_fsm #(.HALT_OP(6'b111111), .CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [3:0]       state;
        logic             pc_write;
        logic [1:0]       pc_src;
        logic             ir_write;
        logic             ext_src;
        logic             alu_src_b;
        logic [2:0]       alu_op;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic [1:0]       reg_dst;
        logic             wr_data_src;
        logic             mem_to_reg;
        logic [CNT_W-1:0] ins_count;
    } obs_t;

    typedef enum {K_J, K_JAL, K_JR, K_BR, K_LW, K_SW, K_AL, K_NOP, K_HALT} kind_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       zero;
        int         ncyc;
        logic [1:0] last_pc_src;
    } vec_t;

    function automatic obs_t sample();
        obs_t o;
        o.state       = bus.state;
        o.pc_write    = bus.PCWrite;
        o.pc_src      = bus.PCSrc;
        o.ir_write    = bus.IRWrite;
        o.ext_src     = bus.ExtSrc;
        o.alu_src_b   = bus.ALUSrcB;
        o.alu_op      = bus.ALUOp;
        o.mem_read    = bus.MemRead;
        o.mem_write   = bus.MemWrite;
        o.reg_write   = bus.RegWrite;
        o.reg_dst     = bus.RegDst;
        o.wr_data_src = bus.WrDataSrc;
        o.mem_to_reg  = bus.MemtoReg;
        o.ins_count   = bus.InsCount;
        return o;
    endfunction

    function automatic kind_t classify(logic [5:0] op, logic [5:0] func);
        case (op)
            6'b000000: return (func == 6'b001000) ? K_JR : K_AL;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b000100, 6'b000101: return K_BR;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b001001, 6'b001010, 6'b001100, 6'b001101: return K_AL;
            6'b111111: return K_HALT;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int path_len(kind_t k);
        case (k)
            K_BR:        return 3;
            K_AL, K_SW:  return 4;
            K_LW:        return 5;
            default:     return 2;
        endcase
    endfunction

    // State visited at cycle position p of an instruction of kind k.
    function automatic logic [3:0] path_state(kind_t k, int p);
        logic [3:0] al[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [3:0] sw[4] = '{4'd0, 4'd1, 4'd5, 4'd6};
        logic [3:0] lw[5] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7};
        if (p < 2) return p[3:0];
        case (k)
            K_BR:    return 4'd4;
            K_AL:    return al[p];
            K_SW:    return sw[p];
            K_LW:    return lw[p];
            default: return 4'd8;
        endcase
    endfunction

    // Expected outputs at cycle position p of the instruction (op, func, zero).
    function automatic obs_t exp_at(logic [5:0] op, logic [5:0] func, logic zero, int p,
                                    int unsigned cnt);
        obs_t  e = '0;
        kind_t k = classify(op, func);
        bit    last = (k != K_HALT) && (p == path_len(k) - 1);
        e.state     = path_state(k, p);
        e.ins_count = cnt[CNT_W-1:0];
        if (p == 0) e.ir_write = 1'b1;
        if (p >= 2 && k != K_HALT) begin
            case (op)
                6'b000000:                   e.alu_op = 3'd7;
                6'b001001, 6'b100011, 6'b101011: begin e.alu_src_b = 1; e.ext_src = 1; end
                6'b001010: begin e.alu_op = 3'd4; e.alu_src_b = 1; e.ext_src = 1; end
                6'b001100: begin e.alu_op = 3'd2; e.alu_src_b = 1; end
                6'b001101: begin e.alu_op = 3'd3; e.alu_src_b = 1; end
                default:   begin e.alu_op = 3'd1; e.ext_src = 1; end
            endcase
        end
        if (last) begin
            e.pc_write = 1'b1;
            case (k)
                K_J, K_JAL: e.pc_src = 2'b10;
                K_JR:       e.pc_src = 2'b11;
                K_BR:       e.pc_src = ((op == 6'b000100) == zero) ? 2'b01 : 2'b00;
                default:    e.pc_src = 2'b00;
            endcase
        end
        if (last && k == K_JAL) begin e.reg_write = 1; e.reg_dst = 2'b10; end
        if (last && k == K_AL) begin
            e.reg_write   = 1;
            e.reg_dst     = (op == 6'b000000) ? 2'b01 : 2'b00;
            e.wr_data_src = 1;
        end
        if (k == K_SW && p == 3) e.mem_write = 1;
        if (k == K_LW && p >= 3) e.mem_read = 1;
        if (k == K_LW && p == 4) begin e.reg_write = 1; e.mem_to_reg = 1; e.wr_data_src = 1; end
        return e;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs one instruction from IF, comparing every cycle against the model.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input logic zero,
                             input string name);
        int n = path_len(classify(op, func));
        bus.op   = op;
        bus.func = func;
        bus.zero = zero;
        for (int p = 0; p < n; p++) begin
            check($sformatf("%s[%0d]", name, p), sample(), exp_at(op, func, zero, p, cnt_m));
            step();
        end
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         ncyc = 0;
        logic [1:0] pcs  = 2'bxx;
        bus.op   = v.op;
        bus.func = v.func;
        bus.zero = v.zero;
        for (int p = 0; p < 8 && ncyc == 0; p++) begin
            if (bus.PCWrite === 1'b1) begin
                ncyc = p + 1;
                pcs  = bus.PCSrc;
            end
            step();
        end
        check_val($sformatf("vec%0d cycles", idx), ncyc, v.ncyc);
        check_val($sformatf("vec%0d pcsrc", idx), pcs, v.last_pc_src);
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
    endtask

    initial begin
        vec_t vecs[15];
        logic [5:0] rops[13] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23,
                                 6'h2b, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h30};
        logic [5:0] rfuncs[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};

        vecs[0]  = '{6'h02, 6'h00, 1'b0, 2, 2'b10};  // j
        vecs[1]  = '{6'h03, 6'h00, 1'b0, 2, 2'b10};  // jal
        vecs[2]  = '{6'h00, 6'h08, 1'b0, 2, 2'b11};  // jr
        vecs[3]  = '{6'h04, 6'h00, 1'b1, 3, 2'b01};  // beq taken
        vecs[4]  = '{6'h04, 6'h00, 1'b0, 3, 2'b00};  // beq not taken
        vecs[5]  = '{6'h05, 6'h00, 1'b0, 3, 2'b01};  // bne taken
        vecs[6]  = '{6'h05, 6'h00, 1'b1, 3, 2'b00};  // bne not taken
        vecs[7]  = '{6'h23, 6'h00, 1'b0, 5, 2'b00};  // lw
        vecs[8]  = '{6'h2b, 6'h00, 1'b0, 4, 2'b00};  // sw
        vecs[9]  = '{6'h09, 6'h00, 1'b0, 4, 2'b00};  // addiu
        vecs[10] = '{6'h0a, 6'h00, 1'b0, 4, 2'b00};  // slti
        vecs[11] = '{6'h0c, 6'h00, 1'b0, 4, 2'b00};  // andi
        vecs[12] = '{6'h0d, 6'h00, 1'b0, 4, 2'b00};  // ori
        vecs[13] = '{6'h30, 6'h00, 1'b0, 2, 2'b00};  // undefined -> NOP
        vecs[14] = '{6'h00, 6'h22, 1'b0, 4, 2'b00};  // sub

        vectors     = 0;
        miscompares = 0;
        cnt_m       = 0;
        bus.op      = 6'h00;
        bus.func    = 6'h00;
        bus.zero    = 1'b0;
        Reset       = 1'b1;
        #1 Reset    = 1'b0;
        #1;
        check("reset state", sample(), '0);
        step();
        check("reset held", sample(), '0);

        @(negedge CLK) Reset = 1'b1;
        #1;
        run_instr(6'h00, 6'h20, 1'b0, "add");
        check_val("add count", bus.InsCount, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);
        check_val("table count", bus.InsCount, cnt_m);

        for (int i = 0; i < 60; i++) begin
            int         sel = $urandom_range(0, 12);
            logic [5:0] f   = rops[sel] == 6'h00 ? rfuncs[$urandom_range(0, 5)]
                                                 : 6'($urandom_range(0, 63));
            run_instr(rops[sel], f, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // Reset asserted in the middle of a store's MEM cycle.
        bus.op = 6'h2b;
        for (int p = 0; p < 3; p++) step();
        check_val("sw MEM MemWrite", bus.MemWrite, 1);
        #2 Reset = 1'b0;
        #1;
        check_val("mid-reset MemWrite", bus.MemWrite, 0);
        check_val("mid-reset state", bus.state, 0);
        check_val("mid-reset count", bus.InsCount, 0);
        cnt_m = 0;
        @(negedge CLK) Reset = 1'b1;
        #1;
        check_val("post-reset IRWrite", bus.IRWrite, 1);
        run_instr(6'h2b, 6'h00, 1'b0, "sw after reset");
        run_instr(6'h23, 6'h00, 1'b0, "lw after reset");

        // HALT parks the FSM with every enable low and the counter frozen.
        bus.op = 6'h3f;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("halt[%0d]", p), sample(), exp_at(6'h3f, 6'h00, 1'b0, p, cnt_m));
            step();
        end
        for (int c = 0; c < 20; c++) begin
            check($sformatf("halt park %0d", c), sample(), exp_at(6'h3f, 6'h00, 1'b0, 2, cnt_m));
            step();
        end
        Reset = 1'b0;
        #1;
        check_val("halt exit state", bus.state, 0);
        #2 Reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
